// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   // Wide enough for any supported DATA_W; users slice to DATA_W/8.
   localparam int unsigned BE_W_MAX = 64;
   localparam logic [BE_W_MAX-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and data
// memory (DM), one outstanding transaction at a time.
// Optional macro MEM_ARB_RR_EN: round-robin IF/DM priority instead of fixed
// DM-over-IF priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ready,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ready,
   input  logic                flush_if,
   output logic                stall_if,
   output logic                stall_mem,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned BE_W = DATA_W / 8;
   localparam logic [BE_W-1:0] FETCH_BE = BE_ALL[BE_W-1:0];

   arb_state_t state, state_nxt;
   owner_t     owner;
   logic       kill;
   logic       dm_sel;
   logic       load_dm, load_if, drop_req, kill_set, kill_clr;

`ifdef MEM_ARB_RR_EN
   owner_t     last_owner;
`endif

   // Priority select: DM wins unless round-robin hands the tie to IF.
   always_comb begin
`ifdef MEM_ARB_RR_EN
      dm_sel = dm_req & (~if_req | (last_owner == OWN_IF));
`else
      dm_sel = dm_req;
`endif
   end

   // Next-state and datapath control strobes.
   always_comb begin
      state_nxt = state;
      load_dm   = 1'b0;
      load_if   = 1'b0;
      drop_req  = 1'b0;
      kill_clr  = 1'b0;
      kill_set  = flush_if && (owner == OWN_IF) &&
                  ((state == ARB_REQ) || (state == ARB_WAIT));
      case (state)
         ARB_IDLE: begin
            if (dm_sel) begin
               load_dm   = 1'b1;
               state_nxt = ARB_REQ;
            end else if (if_req) begin
               load_if   = 1'b1;
               state_nxt = ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (mem_gnt) begin
               drop_req  = 1'b1;
               state_nxt = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (mem_rvalid) begin
               kill_clr  = 1'b1;
               state_nxt = ARB_IDLE;
            end
         end
         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARB_IDLE;
      else        state <= state_nxt;
   end

   // Request fields, owner and kill flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         owner     <= OWN_IF;
         kill      <= 1'b0;
      end else begin
         if (load_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            owner     <= OWN_DM;
         end else if (load_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= FETCH_BE;
            owner     <= OWN_IF;
         end else if (drop_req) begin
            mem_req   <= 1'b0;
         end
         // A flush coinciding with rvalid is covered combinationally on
         // if_ready, so clearing on IDLE entry takes precedence here.
         if (kill_clr)      kill <= 1'b0;
         else if (kill_set) kill <= 1'b1;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remembers who owned the previous transaction for tie-breaking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       last_owner <= OWN_IF;
      else if (load_dm) last_owner <= OWN_DM;
      else if (load_if) last_owner <= OWN_IF;
   end
`endif

   // Response steering, ready pulses and same-cycle stalls.
   always_comb begin
      if_rdata  = mem_rdata;
      dm_rdata  = mem_rdata;
      if_ready  = (state == ARB_WAIT) && (owner == OWN_IF) && mem_rvalid &&
                  !kill && !flush_if;
      dm_ready  = (state == ARB_WAIT) && (owner == OWN_DM) && mem_rvalid;
      stall_if  = if_req & ~if_ready;
      stall_mem = dm_req & ~dm_ready;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build).
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        flush_if;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int unsigned total = 0;
   int unsigned bad   = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .flush_if(flush_if), .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then changed 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; dm_req = 0; dm_we = 0; flush_if = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   initial begin
      rst_n = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
      idle_inputs();
      #12;
      // Reset values
      check("rst_mem_req",  {63'd0, mem_req}, 64'd0);
      check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      check("rst_mem_be",   {60'd0, mem_be}, 64'd0);
      check("rst_state",    {62'd0, dut.state}, {62'd0, ARB_IDLE});
      rst_n = 1;
      step();

      // 1: fetch 0x100, gnt with mem_req, rvalid next cycle
      if_req = 1; if_addr = 32'h100; settle();
      check("t1_c0_stall_if", {63'd0, stall_if}, 64'd1);
      check("t1_c0_mem_req",  {63'd0, mem_req}, 64'd0);
      step();
      mem_gnt = 1; settle();
      check("t1_c1_mem_req",  {63'd0, mem_req}, 64'd1);
      check("t1_c1_mem_addr", {32'd0, mem_addr}, 64'h100);
      check("t1_c1_mem_we",   {63'd0, mem_we}, 64'd0);
      check("t1_c1_mem_be",   {60'd0, mem_be}, 64'hF);
      check("t1_c1_stall_if", {63'd0, stall_if}, 64'd1);
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093; settle();
      check("t1_c2_mem_req",  {63'd0, mem_req}, 64'd0);
      check("t1_c2_if_ready", {63'd0, if_ready}, 64'd1);
      check("t1_c2_if_rdata", {32'd0, if_rdata}, 64'h00500093);
      check("t1_c2_stall_if", {63'd0, stall_if}, 64'd0);
      check("t1_c2_dm_ready", {63'd0, dm_ready}, 64'd0);
      step();
      idle_inputs(); settle();
      check("t1_c3_if_ready", {63'd0, if_ready}, 64'd0);
      step();

      // 2: simultaneous IF 0x104 and DM load 0x2000; DM first
      if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
      step();
      mem_gnt = 1; settle();
      check("t2_dm_addr_first", {32'd0, mem_addr}, 64'h2000);
      check("t2_dm_we",         {63'd0, mem_we}, 64'd0);
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h12345678; settle();
      check("t2_dm_ready",   {63'd0, dm_ready}, 64'd1);
      check("t2_dm_rdata",   {32'd0, dm_rdata}, 64'h12345678);
      check("t2_if_ready0",  {63'd0, if_ready}, 64'd0);
      check("t2_stall_if",   {63'd0, stall_if}, 64'd1);
      check("t2_stall_mem",  {63'd0, stall_mem}, 64'd0);
      step();
      dm_req = 0; mem_rvalid = 0;
      step();
      mem_gnt = 1; settle();
      check("t2_if_mem_req",  {63'd0, mem_req}, 64'd1);
      check("t2_if_mem_addr", {32'd0, mem_addr}, 64'h104);
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00000013; settle();
      check("t2_if_ready", {63'd0, if_ready}, 64'd1);
      step();
      idle_inputs();
      step();

      // 3: store with grant delayed three cycles
      dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_wdata = 32'hDEADBEEF; dm_addr = 32'h3000;
      step();
      for (int i = 0; i < 3; i++) begin
         settle();
         check("t3_hold_req",   {63'd0, mem_req}, 64'd1);
         check("t3_hold_we",    {63'd0, mem_we}, 64'd1);
         check("t3_hold_addr",  {32'd0, mem_addr}, 64'h3000);
         check("t3_hold_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
         check("t3_hold_be",    {60'd0, mem_be}, 64'h3);
         check("t3_hold_stall", {63'd0, stall_mem}, 64'd1);
         step();
      end
      mem_gnt = 1; settle();
      check("t3_gnt_req", {63'd0, mem_req}, 64'd1);
      step();
      mem_gnt = 0; settle();
      check("t3_wait_req",   {63'd0, mem_req}, 64'd0);
      check("t3_wait_ready", {63'd0, dm_ready}, 64'd0);
      step();
      mem_rvalid = 1; settle();
      check("t3_dm_ready", {63'd0, dm_ready}, 64'd1);
      step();
      idle_inputs();
      step();

      // 4: fetch 0x200 flushed in WAIT, then fetch 0x300
      if_req = 1; if_addr = 32'h200;
      step();
      mem_gnt = 1;
      step();
      mem_gnt = 0; flush_if = 1; settle();
      check("t4_flush_ready", {63'd0, if_ready}, 64'd0);
      step();
      flush_if = 0; if_addr = 32'h300;
      step();
      mem_rvalid = 1; settle();
      check("t4_killed_ready", {63'd0, if_ready}, 64'd0);
      check("t4_killed_stall", {63'd0, stall_if}, 64'd1);
      step();
      mem_rvalid = 0; settle();
      check("t4_idle_req", {63'd0, mem_req}, 64'd0);
      step();
      mem_gnt = 1; settle();
      check("t4_next_req",  {63'd0, mem_req}, 64'd1);
      check("t4_next_addr", {32'd0, mem_addr}, 64'h300);
      step();
      mem_gnt = 0; mem_rvalid = 1; flush_if = 1; settle();
      check("t4_flush_rvalid", {63'd0, if_ready}, 64'd0);
      step();
      idle_inputs();
      step();

      // 5: reset in WAIT, stray rvalid afterwards
      if_req = 1; if_addr = 32'h400;
      step();
      mem_gnt = 1;
      step();
      mem_gnt = 0; rst_n = 0; if_req = 0; settle();
      check("t5_rst_req",   {63'd0, mem_req}, 64'd0);
      check("t5_rst_addr",  {32'd0, mem_addr}, 64'd0);
      check("t5_rst_state", {62'd0, dut.state}, {62'd0, ARB_IDLE});
      step();
      rst_n = 1;
      step();
      mem_rvalid = 1; settle();
      check("t5_stray_if", {63'd0, if_ready}, 64'd0);
      check("t5_stray_dm", {63'd0, dm_ready}, 64'd0);
      step();
      mem_rvalid = 0; settle();
      check("t5_state", {62'd0, dut.state}, {62'd0, ARB_IDLE});
      check("t5_req",   {63'd0, mem_req}, 64'd0);
      step();

      // 6: spurious rvalid in IDLE and in REQ
      mem_rvalid = 1; settle();
      check("t6_idle_ready", {63'd0, if_ready | dm_ready}, 64'd0);
      step();
      check("t6_idle_state", {62'd0, dut.state}, {62'd0, ARB_IDLE});
      mem_rvalid = 0; if_req = 1; if_addr = 32'h500;
      step();
      mem_rvalid = 1; settle();
      check("t6_req_ready", {63'd0, if_ready}, 64'd0);
      step();
      mem_rvalid = 0; settle();
      check("t6_req_state", {62'd0, dut.state}, {62'd0, ARB_REQ});
      check("t6_req_held",  {63'd0, mem_req}, 64'd1);
      mem_gnt = 1;
      step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001; settle();
      check("t6_done_ready", {63'd0, if_ready}, 64'd1);
      check("t6_done_rdata", {32'd0, if_rdata}, 64'hCAFE0001);
      step();
      idle_inputs();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the fetch stage (IF) and the memory stage (DM) of the 5-stage pipeline.
- Serialises at most one outstanding transaction and owns the request/grant/response handshake to memory.
- Produces stall_if / stall_mem, which the hazard logic ORs into its stall_f/stall_d and memory-stage stall terms.
- Accepts the branch-flush signal so a fetch already in flight is discarded, not delivered.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held, with if_addr stable, until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid with if_ready
- if_ready  out  1  one-cycle fetch-complete pulse
- dm_req  in  1  data request; held, with fields stable, until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_rdata  out  DATA_W  load data, valid with dm_ready
- dm_ready  out  1  one-cycle data-complete pulse
- flush_if  in  1  branch taken (pcsrc_e); kill any fetch in flight
- stall_if  out  1  = if_req & ~if_ready
- stall_mem  out  1  = dm_req & ~dm_ready
- mem_req  out  1  memory request, registered
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields, registered
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response/ack (for both loads and stores)
- mem_rdata  in  DATA_W  response data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state ARB_IDLE; mem_req = 0; kill = 0; owner = IF.
  - All mem_* fields are 0.
  - if_ready = dm_ready = 0.
  - Reset mid-transaction abandons the transaction. A later mem_rvalid arriving in IDLE is ignored.
- FSM:
  - ARB_IDLE:
    - If dm_req, latch the DM fields and set owner = DM.
    - Else if if_req, latch if_addr with we = 0, be = all ones, and set owner = IF.
    - Either case → ARB_REQ; mem_req rises the next cycle.
  - ARB_REQ:
    - mem_req = 1 with fields held until mem_gnt.
    - On mem_gnt, drop mem_req next cycle → ARB_WAIT.
    - The request is never retracted before grant.
  - ARB_WAIT:
    - On mem_rvalid, return to ARB_IDLE.
    - owner's ready = mem_rvalid combinationally in this state; rdata passes through from mem_rdata.
    - mem_rvalid outside ARB_WAIT is ignored. Grant and rvalid never coincide; rvalid comes ≥1 cycle after gnt.
- Latency:
  - Minimum is 3 cycles from req to ready (req@0, mem_req@1 with gnt@1, rvalid/ready@2).
  - A new transaction may start in the IDLE cycle that follows ready.
- Priority: DM has fixed priority over IF, since the older instruction wins. Simultaneous requests in IDLE select DM.
- Flush:
  - flush_if while owner = IF in ARB_REQ or ARB_WAIT sets kill.
  - The transaction still completes on the port, but if_ready is suppressed.
  - flush_if in the same cycle as the fetch rvalid also suppresses if_ready.
  - kill clears on entry to ARB_IDLE.
  - flush_if in IDLE, or while owner = DM, has no effect.
- Stalls are combinational, with no registered delay, so the hazard unit freezes the same cycle.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin priority between IF and DM. A last_owner flop (reset value IF) gives the tie to the requester that did not own the previous transaction.
- Undefined: fixed DM-over-IF priority as above; no last_owner flop.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT}
  - typedef enum logic owner_t {OWN_IF, OWN_DM}
  - localparam BE_ALL used for fetch byte enables
- Single module; no sub-module is warranted.

Test Plan:
1. if_req = 1, if_addr = 0x100; gnt same cycle as mem_req, rvalid 1 cycle later with rdata 0x00500093 → if_ready pulses at cycle 2, if_rdata = 0x00500093, stall_if = 1 on cycles 0–1.
2. if_req and dm_req (load, 0x2000) both rise at cycle 0 → mem_addr = 0x2000 issued first, dm_ready first, then fetch 0x104 issued. With MEM_ARB_RR_EN and last_owner = DM, fetch goes first.
3. Store dm_we = 1, be = 4'b0011, wdata = 0xDEADBEEF; gnt delayed 3 cycles → mem_req and fields stable all 3 cycles; dm_ready only on rvalid.
4. Fetch 0x200 in ARB_WAIT, flush_if pulses, rvalid 2 cycles later → no if_ready. The next fetch, 0x300, is issued from IDLE the following cycle.
5. rst_n dropped in ARB_WAIT, then a stray mem_rvalid after release → all outputs at reset values, no ready pulse, state stays ARB_IDLE.
6. mem_rvalid asserted spuriously in ARB_IDLE and in ARB_REQ → ignored: no ready pulse, no state change.
